pll_reset_sequencer: RTL and testbench



---
 rtl/pll_reset_sequencer.sv | 133 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock-qualification sequencer for the pixel-clock PLL.
// Holds the PLL in reset, waits for a stable lock, then releases the pixel-domain reset.
module pll_reset_sequencer #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked_in,
    output logic       pll_rst,
    output logic       user_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam int HW = (RST_HOLD_CYCLES     > 1) ? $clog2(RST_HOLD_CYCLES)     : 1;
    localparam int SW = (LOCK_STABLE_CYCLES  > 1) ? $clog2(LOCK_STABLE_CYCLES)  : 1;
    localparam int TW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;

    localparam logic [HW-1:0] H_LAST = HW'(RST_HOLD_CYCLES - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    R_MAX  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RESET_PLL,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t        state, state_n;
    logic [1:0]    sync_q;
    logic          locked_s;
    logic [HW-1:0] hcnt, hcnt_n;
    logic [SW-1:0] scnt, scnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [3:0]    retry_n;
    logic [7:0]    loss_n;

    // locked_in is asynchronous to refclk
    always_ff @(posedge refclk) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], locked_in};
    end
    assign locked_s = sync_q[1];

    always_ff @(posedge refclk) begin
        if (rst) begin
            state         <= ST_RESET_PLL;
            hcnt          <= '0;
            scnt          <= '0;
            tcnt          <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
        end else begin
            state         <= state_n;
            hcnt          <= hcnt_n;
            scnt          <= scnt_n;
            tcnt          <= tcnt_n;
            retry_cnt     <= retry_n;
            lock_loss_cnt <= loss_n;
        end
    end

    always_comb begin
        state_n = state;
        hcnt_n  = hcnt;
        scnt_n  = scnt;
        tcnt_n  = tcnt;
        retry_n = retry_cnt;
        loss_n  = lock_loss_cnt;
        case (state)
            ST_RESET_PLL: begin
                if (hcnt == H_LAST) begin
                    state_n = ST_WAIT_LOCK;
                    hcnt_n  = '0;
                    tcnt_n  = '0;
                end else begin
                    hcnt_n = hcnt + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                // a lock seen on the timeout cycle still counts as a lock
                if (locked_s) begin
                    state_n = ST_STABLE;
                    scnt_n  = '0;
                end else if (tcnt == T_LAST) begin
                    if (retry_cnt < R_MAX) begin
                        retry_n = retry_cnt + 4'd1;
                        state_n = ST_RESET_PLL;
                        hcnt_n  = '0;
                    end else begin
                        state_n = ST_FAIL;
                    end
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_n = ST_WAIT_LOCK;
                    tcnt_n  = '0;
                end else if (scnt == S_LAST) begin
                    state_n = ST_RUN;
                end else begin
                    scnt_n = scnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_n = ST_RESET_PLL;
                    hcnt_n  = '0;
                    retry_n = '0;
                    if (lock_loss_cnt != 8'hFF) loss_n = lock_loss_cnt + 8'd1;
                end
            end
            ST_FAIL: ;
            default: state_n = ST_RESET_PLL;
        endcase
    end

    assign pll_rst  = (state == ST_RESET_PLL) || (state == ST_FAIL);
    assign user_rst = (state != ST_RUN);
    assign ready    = (state == ST_RUN);
    assign fail     = (state == ST_FAIL);

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with H=4, S=8, T=32, MAX_RETRIES=2.
// "Cycle k" is the output seen after k edges with rst low.
module tb_pll_reset_sequencer;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       locked_in = 1'b0;
    logic       pll_rst, user_rst, ready, fail;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int checks = 0;
    int errors = 0;
    int ecount = 0;

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES(4),
        .LOCK_STABLE_CYCLES(8),
        .LOCK_TIMEOUT_CYCLES(32),
        .MAX_RETRIES(2)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .locked_in(locked_in),
        .pll_rst(pll_rst),
        .user_rst(user_rst),
        .ready(ready),
        .fail(fail),
        .retry_cnt(retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #10 refclk = ~refclk;

    typedef struct {
        int         cyc;
        logic       lk;
        logic       prst, urst, rdy, fl;
        logic [3:0] rc;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        ecount++;
        @(negedge refclk);
    endtask

    task automatic goto(input int k);
        while (ecount < k) tick();
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, " pll_rst"},  8'(pll_rst),  8'd1);
        chk({nm, " user_rst"}, 8'(user_rst), 8'd1);
        chk({nm, " ready"},    8'(ready),    8'd0);
        chk({nm, " fail"},     8'(fail),     8'd0);
        chk({nm, " retry"},    8'(retry_cnt), 8'd0);
        chk({nm, " loss"},     lock_loss_cnt, 8'd0);
    endtask

    task automatic do_reset(input logic lk);
        rst = 1'b1;
        locked_in = lk;
        tick();
        tick();
        chk_reset_outs("rst_high");
        rst = 1'b0;
        ecount = 0;
    endtask

    task automatic wait_ready(input logic val, input int budget, input string nm);
        int n = 0;
        while (ready !== val && n < budget) begin
            tick();
            n++;
        end
        chk(nm, 8'(ready), 8'(val));
    endtask

    function automatic vec_t mk(input int c, input logic lk, input logic p, input logic u,
                                input logic r, input logic f, input logic [3:0] rc);
        vec_t v;
        v.cyc = c; v.lk = lk; v.prst = p; v.urst = u; v.rdy = r; v.fl = f; v.rc = rc;
        return v;
    endfunction

    initial begin
        // nominal bring-up with lock present
        tbl[0]  = mk(0,   1'b1, 1, 1, 0, 0, 0);
        tbl[1]  = mk(3,   1'b1, 1, 1, 0, 0, 0);
        tbl[2]  = mk(4,   1'b1, 0, 1, 0, 0, 0);
        tbl[3]  = mk(12,  1'b1, 0, 1, 0, 0, 0);
        tbl[4]  = mk(13,  1'b1, 0, 0, 1, 0, 0);
        tbl[5]  = mk(40,  1'b1, 0, 0, 1, 0, 0);
        // no lock: timeouts, retries, then FAIL
        tbl[6]  = mk(4,   1'b0, 0, 1, 0, 0, 0);
        tbl[7]  = mk(35,  1'b0, 0, 1, 0, 0, 0);
        tbl[8]  = mk(36,  1'b0, 1, 1, 0, 0, 1);
        tbl[9]  = mk(40,  1'b0, 0, 1, 0, 0, 1);
        tbl[10] = mk(71,  1'b0, 0, 1, 0, 0, 1);
        tbl[11] = mk(72,  1'b0, 1, 1, 0, 0, 2);
        tbl[12] = mk(107, 1'b0, 0, 1, 0, 0, 2);
        tbl[13] = mk(108, 1'b0, 1, 1, 0, 1, 2);
        tbl[14] = mk(200, 1'b0, 1, 1, 0, 1, 2);
        tbl[15] = mk(400, 1'b1, 1, 1, 0, 1, 2);

        for (int i = 0; i < 16; i++) begin
            if (i == 0 || i == 6) do_reset(tbl[i].lk);
            locked_in = tbl[i].lk;
            goto(tbl[i].cyc);
            chk($sformatf("vec%0d pll_rst", i),  8'(pll_rst),   8'(tbl[i].prst));
            chk($sformatf("vec%0d user_rst", i), 8'(user_rst),  8'(tbl[i].urst));
            chk($sformatf("vec%0d ready", i),    8'(ready),     8'(tbl[i].rdy));
            chk($sformatf("vec%0d fail", i),     8'(fail),      8'(tbl[i].fl));
            chk($sformatf("vec%0d retry", i),    8'(retry_cnt), 8'(tbl[i].rc));
        end

        // lock loss from RUN: lock dropped at edge 20, reaction visible at 23
        do_reset(1'b1);
        goto(20);
        locked_in = 1'b0;
        goto(22);
        chk("loss N+2 ready", 8'(ready), 8'd1);
        chk("loss N+2 user_rst", 8'(user_rst), 8'd0);
        goto(23);
        chk("loss N+3 ready", 8'(ready), 8'd0);
        chk("loss N+3 user_rst", 8'(user_rst), 8'd1);
        chk("loss N+3 pll_rst", 8'(pll_rst), 8'd1);
        chk("loss N+3 count", lock_loss_cnt, 8'd1);
        locked_in = 1'b1;
        goto(35);
        chk("relock early", 8'(ready), 8'd0);
        goto(36);
        chk("relock ready", 8'(ready), 8'd1);
        chk("relock retry", 8'(retry_cnt), 8'd0);

        // lock glitch in STABLE at stable count 5: full re-qualification
        do_reset(1'b1);
        goto(8);
        locked_in = 1'b0;
        goto(11);
        locked_in = 1'b1;
        goto(13);
        chk("glitch nominal ready", 8'(ready), 8'd0);
        goto(21);
        chk("glitch ready early", 8'(ready), 8'd0);
        chk("glitch pll_rst", 8'(pll_rst), 8'd0);
        goto(22);
        chk("glitch ready", 8'(ready), 8'd1);
        chk("glitch retry", 8'(retry_cnt), 8'd0);

        // lock seen on the exact timeout cycle wins
        do_reset(1'b0);
        goto(33);
        locked_in = 1'b1;
        goto(35);
        chk("edge-to pll_rst 35", 8'(pll_rst), 8'd0);
        goto(36);
        chk("edge-to pll_rst 36", 8'(pll_rst), 8'd0);
        chk("edge-to retry", 8'(retry_cnt), 8'd0);
        goto(43);
        chk("edge-to ready 43", 8'(ready), 8'd0);
        goto(44);
        chk("edge-to ready 44", 8'(ready), 8'd1);

        // saturating lock-loss counter (first loss already counted below)
        do_reset(1'b1);
        wait_ready(1'b1, 40, "sat first run");
        for (int i = 1; i <= 300; i++) begin
            locked_in = 1'b0;
            wait_ready(1'b0, 10, "sat drop");
            locked_in = 1'b1;
            wait_ready(1'b1, 40, "sat relock");
            if (i == 254) chk("loss cnt 254", lock_loss_cnt, 8'd254);
            if (i == 255) chk("loss cnt 255", lock_loss_cnt, 8'd255);
        end
        chk("loss cnt saturated", lock_loss_cnt, 8'd255);

        // rst asserted mid-STABLE clears everything on the next edge
        begin
            int n0;
            n0 = ecount;
            locked_in = 1'b0;
            goto(n0 + 3);
            locked_in = 1'b1;
            goto(n0 + 10);
            chk("pre-rst loss cnt", lock_loss_cnt, 8'd255);
            rst = 1'b1;
            tick();
            chk_reset_outs("mid_stable_rst");
            rst = 1'b0;
            ecount = 0;
            goto(12);
            chk("post-rst ready 12", 8'(ready), 8'd0);
            goto(13);
            chk("post-rst ready 13", 8'(ready), 8'd1);
            chk("post-rst user_rst", 8'(user_rst), 8'd0);
            chk("post-rst loss cnt", lock_loss_cnt, 8'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
